// File: rtl/snitch_pkg.sv
// Shared accelerator-offload types.
// Request bundle and destination address enum used by the issuer.
package snitch_pkg;

    localparam int unsigned AccAddrWidth = 48;
    localparam int unsigned AccDataWidth = 64;

    typedef enum logic [1:0] {
        FP_SS         = 2'd0,
        SHARED_MULDIV = 2'd1,
        DMA_SS        = 2'd2,
        INT_SS        = 2'd3
    } acc_addr_e;

    typedef struct packed {
        acc_addr_e                 addr;
        logic [4:0]                id;
        logic [31:0]               data_op;
        logic [AccDataWidth-1:0]   data_arga;
        logic [AccDataWidth-1:0]   data_argb;
        logic [AccAddrWidth-1:0]   data_argc;
    } acc_req_t;

endpackage

// File: rtl/stitch_int_scoreboard.sv
// Integer-register scoreboard for offloaded results.
// Tracks busy destinations, in-flight count and stray responses.
module stitch_int_scoreboard
    import snitch_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                set_en,
    input  logic [4:0]          set_rd,
    input  logic                clr_en,
    input  logic [4:0]          clr_rd,
    output logic                full,
    output logic [31:0]         busy,
    output logic [CntWidth-1:0] count,
    output logic                unexpected
);

    logic [31:0]         busy_q, busy_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                unexp_q;
    logic                bad_rsp;
    logic                clr_ok;

    // A response is only legal if something is outstanding and its
    // destination (other than x0) is still marked busy.
    assign bad_rsp = clr_en &
        ((cnt_q == '0) | ((clr_rd != 5'd0) & ~busy_q[clr_rd]));
    assign clr_ok  = clr_en & ~bad_rsp;

    assign full       = (cnt_q == CntWidth'(MaxOutstanding));
    assign busy       = busy_q;
    assign count      = cnt_q;
    assign unexpected = unexp_q;

    always_comb begin
        busy_d = busy_q;
        if (clr_ok) begin
            busy_d[clr_rd] = 1'b0;
        end
        if (set_en && (set_rd != 5'd0)) begin
            busy_d[set_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case (1'b1)
            (set_en & ~clr_ok): cnt_d = cnt_q + 1'b1;
            (clr_ok & ~set_en): cnt_d = cnt_q - 1'b1;
            default:            cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= '0;
            cnt_q   <= '0;
            unexp_q <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            unexp_q <= unexp_q | bad_rsp;
        end
    end

endmodule

// File: rtl/stitch_acc_offload.sv
// Core-side issuer for the accelerator offload interface.
// Single-entry request stage plus pass-through response path.
module stitch_acc_offload
    import snitch_pkg::*;
#(
    parameter int unsigned AddrWidth      = 48,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned MaxOutstanding = 4,
    parameter acc_addr_e   DstAddr        = FP_SS
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 core_valid_i,
    output logic                 core_ready_o,
    input  logic [31:0]          core_op_i,
    input  logic [DataWidth-1:0] core_arga_i,
    input  logic [DataWidth-1:0] core_argb_i,
    input  logic [AddrWidth-1:0] core_argc_i,
    input  logic                 core_wb_i,
    input  logic [4:0]           core_rd_i,
    output logic [31:0]          busy_o,
    output acc_addr_e            oup_qaddr_o,
    output logic [4:0]           oup_qid_o,
    output logic [31:0]          oup_qdata_op_o,
    output logic [DataWidth-1:0] oup_qdata_arga_o,
    output logic [DataWidth-1:0] oup_qdata_argb_o,
    output logic [AddrWidth-1:0] oup_qdata_argc_o,
    output logic                 oup_qvalid_o,
    input  logic                 oup_qready_i,
    input  logic [4:0]           inp_pid_i,
    input  logic [DataWidth-1:0] inp_pdata_i,
    input  logic                 inp_perror_i,
    input  logic                 inp_pvalid_i,
    output logic                 inp_pready_o,
    output logic                 wb_valid_o,
    input  logic                 wb_ready_i,
    output logic [4:0]           wb_rd_o,
    output logic [DataWidth-1:0] wb_data_o,
    output logic                 wb_error_o,
    output logic                 unexpected_rsp_o,
    output logic                 idle_o
);

    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

    acc_req_t            req_q;
    logic                req_valid_q;
    logic                stall;
    logic                core_hs;
    logic                rsp_hs;
    logic                full;
    logic [31:0]         busy;
    logic [CntWidth-1:0] out_cnt;

    assign stall = core_valid_i & core_wb_i & (busy[core_rd_i] | full);
    assign core_ready_o = (~req_valid_q | oup_qready_i) & ~stall;
    assign core_hs = core_valid_i & core_ready_o;
    assign rsp_hs  = inp_pvalid_i & wb_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_valid_q <= 1'b0;
        end else if (core_hs) begin
            req_valid_q <= 1'b1;
        end else if (oup_qready_i) begin
            req_valid_q <= 1'b0;
        end
    end

    // Payload is never reset: it is only observed while valid is high.
    always_ff @(posedge clk_i) begin
        if (core_hs) begin
            req_q.addr      <= DstAddr;
            req_q.id        <= core_rd_i;
            req_q.data_op   <= core_op_i;
            req_q.data_arga <= AccDataWidth'(core_arga_i);
            req_q.data_argb <= AccDataWidth'(core_argb_i);
            req_q.data_argc <= AccAddrWidth'(core_argc_i);
        end
    end

    assign oup_qvalid_o     = req_valid_q;
    assign oup_qaddr_o      = req_q.addr;
    assign oup_qid_o        = req_q.id;
    assign oup_qdata_op_o   = req_q.data_op;
    assign oup_qdata_arga_o = req_q.data_arga[DataWidth-1:0];
    assign oup_qdata_argb_o = req_q.data_argb[DataWidth-1:0];
    assign oup_qdata_argc_o = req_q.data_argc[AddrWidth-1:0];

    assign wb_valid_o   = inp_pvalid_i;
    assign inp_pready_o = wb_ready_i;
    assign wb_rd_o      = inp_pid_i;
    assign wb_data_o    = inp_pdata_i;
    assign wb_error_o   = inp_perror_i;

    stitch_int_scoreboard #(
        .MaxOutstanding(MaxOutstanding)
    ) u_sb (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .set_en     (core_hs & core_wb_i),
        .set_rd     (core_rd_i),
        .clr_en     (rsp_hs),
        .clr_rd     (inp_pid_i),
        .full       (full),
        .busy       (busy),
        .count      (out_cnt),
        .unexpected (unexpected_rsp_o)
    );

    assign busy_o = busy;
    assign idle_o = ~req_valid_q & (out_cnt == '0);

    ap_max_out: assert property (@(posedge clk_i) MaxOutstanding >= 1);

    ap_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (oup_qvalid_o & ~oup_qready_i) |=>
        (oup_qvalid_o & (req_q == $past(req_q))));

endmodule

// File: tb/tb_stitch_acc_offload.sv
// Self-checking bench for stitch_acc_offload.
// Vector table for the response path, scoreboard for requests.
module tb_stitch_acc_offload;
    import snitch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_valid = 1'b0;
    logic        core_ready;
    logic [31:0] core_op = '0;
    logic [63:0] core_a = '0;
    logic [63:0] core_b = '0;
    logic [47:0] core_c = '0;
    logic        core_wb = 1'b0;
    logic [4:0]  core_rd = '0;
    logic [31:0] busy;
    acc_addr_e   qaddr;
    logic [4:0]  qid;
    logic [31:0] qop;
    logic [63:0] qa, qb;
    logic [47:0] qc;
    logic        qvalid;
    logic        qready = 1'b1;
    logic [4:0]  pid = '0;
    logic [63:0] pdata = '0;
    logic        perror = 1'b0;
    logic        pvalid = 1'b0;
    logic        pready;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        wb_error;
    logic        unexp;
    logic        idle;

    int n_checks = 0;
    int n_fail = 0;
    int n_pop = 0;
    int cyc = 0;
    bit strict_lat = 1'b0;

    typedef struct {
        logic [4:0]  id;
        logic [31:0] op;
        logic [63:0] a;
        logic [63:0] b;
        logic [47:0] c;
        int          cyc;
    } req_rec_t;

    req_rec_t sbq[$];

    typedef struct {
        logic        pvalid;
        logic [4:0]  pid;
        logic [63:0] pdata;
        logic        perror;
        logic        wbr;
        logic        e_wbv;
        logic [4:0]  e_rd;
        logic [63:0] e_data;
        logic        e_err;
        logic        e_pready;
    } rsp_vec_t;

    stitch_acc_offload dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .core_valid_i     (core_valid),
        .core_ready_o     (core_ready),
        .core_op_i        (core_op),
        .core_arga_i      (core_a),
        .core_argb_i      (core_b),
        .core_argc_i      (core_c),
        .core_wb_i        (core_wb),
        .core_rd_i        (core_rd),
        .busy_o           (busy),
        .oup_qaddr_o      (qaddr),
        .oup_qid_o        (qid),
        .oup_qdata_op_o   (qop),
        .oup_qdata_arga_o (qa),
        .oup_qdata_argb_o (qb),
        .oup_qdata_argc_o (qc),
        .oup_qvalid_o     (qvalid),
        .oup_qready_i     (qready),
        .inp_pid_i        (pid),
        .inp_pdata_i      (pdata),
        .inp_perror_i     (perror),
        .inp_pvalid_i     (pvalid),
        .inp_pready_o     (pready),
        .wb_valid_o       (wb_valid),
        .wb_ready_i       (wb_ready),
        .wb_rd_o          (wb_rd),
        .wb_data_o        (wb_data),
        .wb_error_o       (wb_error),
        .unexpected_rsp_o (unexp),
        .idle_o           (idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Request monitor: pop on downstream handshake, push on acceptance.
    always @(negedge clk) begin : mon
        req_rec_t e;
        if (rst_n) begin
            if (qvalid && qready) begin
                if (sbq.size() == 0) begin
                    check("spurious_req", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("qid", qid, e.id);
                    check("qop", qop, e.op);
                    check("qarga", qa, e.a);
                    check("qargb", qb, e.b);
                    check("qargc", qc, e.c);
                    check("qaddr", qaddr, FP_SS);
                    if (strict_lat) check("req_latency", cyc - e.cyc, 1);
                end
                n_pop++;
            end
            if (core_valid && core_ready)
                sbq.push_back('{core_rd, core_op, core_a, core_b, core_c, cyc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_core(input logic w, input logic [4:0] r);
        core_valid = 1'b1;
        core_wb = w;
        core_rd = r;
        core_op = $urandom;
        core_a = {$urandom, $urandom};
        core_b = {$urandom, $urandom};
        core_c = {16'($urandom), $urandom};
    endtask

    task automatic respond(input logic [4:0] id, input logic [63:0] d);
        pvalid = 1'b1;
        pid = id;
        pdata = d;
        wb_ready = 1'b1;
        settle();
        check("rsp_wb_valid", wb_valid, 1);
        tick();
        pvalid = 1'b0;
        wb_ready = 1'b0;
    endtask

    rsp_vec_t vecs[4];

    initial begin
        logic [31:0] s_op;
        logic [63:0] s_a;
        int pop0;

        vecs[0] = '{1, 5'd3, 64'hDEAD, 0, 0, 1, 5'd3, 64'hDEAD, 0, 0};
        vecs[1] = '{0, 5'd9, 64'h1234, 1, 1, 0, 5'd9, 64'h1234, 1, 1};
        vecs[2] = '{1, 5'd31, 64'hFFFF_0000_FFFF_0001, 1, 0,
                    1, 5'd31, 64'hFFFF_0000_FFFF_0001, 1, 0};
        vecs[3] = '{0, 5'd0, 64'h0, 0, 0, 0, 5'd0, 64'h0, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_qvalid", qvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_idle", idle, 1);
        check("rst_unexp", unexp, 0);
        check("rst_core_ready", core_ready, 1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            pvalid = vecs[i].pvalid;
            pid = vecs[i].pid;
            pdata = vecs[i].pdata;
            perror = vecs[i].perror;
            wb_ready = vecs[i].wbr;
            settle();
            check("vec_wb_valid", wb_valid, vecs[i].e_wbv);
            check("vec_wb_rd", wb_rd, vecs[i].e_rd);
            check("vec_wb_data", wb_data, vecs[i].e_data);
            check("vec_wb_error", wb_error, vecs[i].e_err);
            check("vec_pready", pready, vecs[i].e_pready);
            tick();
        end
        pvalid = 0; wb_ready = 0; perror = 0;
        check("vec_no_unexp", unexp, 0);

        // Stream of 8 non-writeback ops
        strict_lat = 1'b1;
        pop0 = n_pop;
        for (int i = 0; i < 8; i++) begin
            drive_core(0, 5'(i + 1));
            settle();
            check("stream_ready", core_ready, 1);
            check("stream_busy", busy, 0);
            tick();
        end
        core_valid = 0;
        tick();
        tick();
        strict_lat = 1'b0;
        check("stream_pops", n_pop - pop0, 8);
        check("stream_idle", idle, 1);

        // Hazard on x5
        drive_core(1, 5);
        settle();
        check("haz_first_ready", core_ready, 1);
        tick();
        drive_core(1, 5);
        settle();
        check("haz_stall", core_ready, 0);
        check("haz_busy5", busy, 32'h20);
        tick();
        settle();
        check("haz_stall2", core_ready, 0);
        tick();
        pvalid = 1; pid = 5; pdata = 64'h55; wb_ready = 1;
        settle();
        check("haz_no_bypass", core_ready, 0);
        check("haz_wb_rd", wb_rd, 5);
        tick();
        pvalid = 0; wb_ready = 0;
        settle();
        check("haz_cleared", busy, 0);
        check("haz_release", core_ready, 1);
        tick();
        core_valid = 0;
        settle();
        check("haz_busy_again", busy, 32'h20);
        respond(5, 64'h56);
        settle();
        check("haz_idle", idle, 1);

        // Outstanding cap
        for (int r = 1; r <= 4; r++) begin
            drive_core(1, 5'(r));
            settle();
            check("cap_accept", core_ready, 1);
            tick();
        end
        drive_core(1, 5);
        settle();
        check("cap_stall", core_ready, 0);
        check("cap_count4", dut.out_cnt, 4);
        tick();
        settle();
        check("cap_stall2", core_ready, 0);
        pvalid = 1; pid = 2; wb_ready = 1;
        settle();
        check("cap_stall_rsp", core_ready, 0);
        tick();
        pvalid = 0; wb_ready = 0;
        settle();
        check("cap_release", core_ready, 1);
        check("cap_count3", dut.out_cnt, 3);
        tick();
        core_valid = 0;
        settle();
        check("cap_count_back4", dut.out_cnt, 4);
        check("cap_busy", busy, 32'h3A);
        respond(1, 1); respond(3, 3); respond(4, 4); respond(5, 5);
        settle();
        check("cap_drained", dut.out_cnt, 0);

        // Backpressure
        qready = 0;
        pop0 = n_pop;
        drive_core(0, 10);
        s_op = core_op;
        s_a = core_a;
        settle();
        check("bp_accept", core_ready, 1);
        tick();
        drive_core(0, 11);
        for (int k = 0; k < 3; k++) begin
            settle();
            check("bp_qvalid", qvalid, 1);
            check("bp_op_stable", qop, s_op);
            check("bp_arga_stable", qa, s_a);
            check("bp_qid", qid, 10);
            check("bp_core_ready", core_ready, 0);
            tick();
        end
        qready = 1;
        settle();
        check("bp_release", core_ready, 1);
        tick();
        core_valid = 0;
        settle();
        check("bp_second_held", qvalid, 1);
        tick();
        settle();
        check("bp_drained", qvalid, 0);
        check("bp_pops", n_pop - pop0, 2);

        // Simultaneous accept (x7) and response (x3)
        drive_core(1, 3);
        tick();
        core_valid = 0;
        settle();
        check("sim_busy3", busy, 32'h8);
        drive_core(1, 7);
        pvalid = 1; pid = 3; wb_ready = 1;
        settle();
        check("sim_ready", core_ready, 1);
        tick();
        core_valid = 0; pvalid = 0; wb_ready = 0;
        settle();
        check("sim_count", dut.out_cnt, 1);
        check("sim_busy7", busy, 32'h80);
        respond(7, 7);

        // x0 destination, error forwarding
        drive_core(1, 0);
        settle();
        check("x0_ready", core_ready, 1);
        tick();
        core_valid = 0;
        settle();
        check("x0_busy", busy, 0);
        check("x0_count", dut.out_cnt, 1);
        check("x0_not_idle", idle, 0);
        pvalid = 1; pid = 0; pdata = 64'hCAFE; perror = 1; wb_ready = 1;
        settle();
        check("err_fwd", wb_error, 1);
        check("err_data", wb_data, 64'hCAFE);
        check("err_rd", wb_rd, 0);
        tick();
        pvalid = 0; wb_ready = 0; perror = 0;
        settle();
        check("x0_count0", dut.out_cnt, 0);
        check("x0_no_unexp", unexp, 0);
        check("x0_idle", idle, 1);

        // Unexpected response to non-busy x9
        respond(9, 9);
        settle();
        check("unexp_set", unexp, 1);
        check("unexp_no_underflow", dut.out_cnt, 0);
        tick();
        tick();
        settle();
        check("unexp_sticky", unexp, 1);

        // Reset while stalled with a held request
        qready = 0;
        drive_core(1, 5);
        tick();
        drive_core(1, 5);
        settle();
        check("rs_stall", core_ready, 0);
        check("rs_qvalid", qvalid, 1);
        check("rs_busy", busy, 32'h20);
        tick();
        #2;
        rst_n = 0;
        #1;
        check("rs_async_qvalid", qvalid, 0);
        check("rs_async_busy", busy, 0);
        check("rs_async_idle", idle, 1);
        check("rs_async_unexp", unexp, 0);
        check("rs_async_count", dut.out_cnt, 0);
        core_valid = 0;
        sbq.delete();
        tick();
        rst_n = 1;
        qready = 1;
        tick();
        tick();
        check("sb_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stitch_acc_offload.md
# stitch_acc_offload

Core-side issuer for the accelerator offload interface: accepts decoded FP/accelerator instructions from the integer core and drives the request channel (`qaddr/qid/qdata_*`, `qvalid/qready`) toward the FPU sequencer. It also terminates the response channel (`pid/pdata/perror`, `pvalid/pready`), forwarding results to the integer register-file write port. An integer-register scoreboard stalls the core on outstanding float-to-int results and WAW hazards.

## Interface
- `AddrWidth`, default 48: width of `argc`.
- `DataWidth`, default 64: width of `arga`, `argb` and `pdata`.
- `MaxOutstanding`, default 4: maximum number of in-flight writeback-carrying requests (≥1).
- `DstAddr`, default `FP_SS`: `acc_addr_e` value driven on `oup_qaddr_o`.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; one clock, asynchronous and active-low.
- `core_valid_i`  in  1  core offers an instruction.
- `core_ready_o`  out  1  instruction accepted.
- `core_op_i`  in  32  RISC-V instruction.
- `core_arga_i`, `core_argb_i`  in  DataWidth  integer operands.
- `core_argc_i`  in  AddrWidth  address operand.
- `core_wb_i`  in  1  instruction returns an integer result.
- `core_rd_i`  in  5  integer destination; only meaningful when `core_wb_i` is set.
- `busy_o`  out  32  scoreboard; bit *n* set means x*n* has a result pending.
- `oup_qaddr_o`  out  acc_addr_e  always `DstAddr`.
- `oup_qid_o`  out  5  `core_rd_i` captured at acceptance.
- `oup_qdata_op_o`, `oup_qdata_arga_o`, `oup_qdata_argb_o`, `oup_qdata_argc_o`  out  as above  captured payload.
- `oup_qvalid_o`  out  1.
- `oup_qready_i`  in  1.
- `inp_pid_i`  in  5.
- `inp_pdata_i`  in  DataWidth.
- `inp_perror_i`  in  1.
- `inp_pvalid_i`  in  1.
- `inp_pready_o`  out  1.
- `wb_valid_o`  out  1  result to regfile.
- `wb_ready_i`  in  1.
- `wb_rd_o`  out  5.
- `wb_data_o`  out  DataWidth.
- `wb_error_o`  out  1.
- `unexpected_rsp_o`  out  1  sticky: a response arrived with no matching busy bit.
- `idle_o`  out  1  no request held and no result outstanding.

## Operation
- **Request stage.** A single-entry register (`req_q`, `req_valid_q`).
  - `oup_qvalid_o = req_valid_q`.
  - `core_ready_o = (~req_valid_q | oup_qready_i) & ~stall`.
  - On a core handshake the payload is loaded; otherwise `req_valid_q` clears on a downstream handshake.
- **Stall.** `stall = core_valid_i & core_wb_i & (busy_q[core_rd_i] | (out_cnt_q == MaxOutstanding))`.
  - `busy_q` is the registered value; there is no same-cycle bypass of a clearing response.
- **Scoreboard update.** Happens on core acceptance, not on downstream issue.
  - If `core_wb_i` and `core_rd_i != 0`: set `busy_q[rd]`.
  - `out_cnt_q` increments on any accepted `core_wb_i` instruction, including rd = 0.
  - `busy_q[0]` is never set.
- **Response path.** Combinational pass-through.
  - `wb_valid_o = inp_pvalid_i`; `inp_pready_o = wb_ready_i`.
  - `wb_rd_o = inp_pid_i`, `wb_data_o = inp_pdata_i`, `wb_error_o = inp_perror_i`.
  - On a response handshake: clear `busy_q[pid]` and decrement `out_cnt_q`.
- **Unexpected response.** A response handshake with `out_cnt_q == 0`, or with `pid != 0` and `busy_q[pid] == 0`:
  - sets `unexpected_rsp_o` (sticky until reset);
  - leaves the counter unchanged, with no underflow.
- **Simultaneous acceptance and response.**
  - The counter holds.
  - The set and clear apply to their own bits. They cannot target the same nonzero bit, because acceptance requires that bit to be clear.
- `idle_o = ~req_valid_q & (out_cnt_q == 0)`.

## Timing
- Reset values:
  - `req_valid_q = 0`, `busy_q = 0`, `out_cnt_q = 0`, `unexpected_rsp_o = 0`.
  - Outputs therefore reset to: `oup_qvalid_o = 0`, `busy_o = 0`, `idle_o = 1`.
  - The request payload registers are not reset; `oup_*` data is don't-care while `oup_qvalid_o = 0`.
- Request latency is 1 cycle from core handshake to `oup_qvalid_o`. Throughput is 1 per cycle while `oup_qready_i` is held high.
- The request stage holds its payload stable while `oup_qvalid_o & ~oup_qready_i`. The valid-before-ready rule is respected: `oup_qvalid_o` never depends on `oup_qready_i`.
- `busy_o` reflects an acceptance the following cycle. A response clears its bit the following cycle, so a dependent instruction can be accepted one cycle after the response handshake.
- Response latency is 0 cycles (combinational). `inp_pready_o` depends only on `wb_ready_i`.
- Asserting reset mid-operation discards the held request and all scoreboard state. Responses still in flight after reset count as unexpected.

## Structure
- Add `acc_req_t` to `snitch_pkg` if it is absent (`addr`, `id`, `data_op`, `data_arga`, `data_argb`, `data_argc`). `acc_addr_e` already lives in `snitch_pkg`.
- One sub-module, `stitch_int_scoreboard`, owns `busy_q`, `out_cnt_q` and the unexpected-response flag. Ports: set-enable/rd, clear-enable/rd, `full`, `busy`, `count`.
- The request register is inline (FFAR on valid, FFNR on payload, per `common_cells/registers.svh`).
- Assertions:
  - `MaxOutstanding >= 1`.
  - The payload is stable while `oup_qvalid_o & ~oup_qready_i`.

## Test plan
- **Stream.** Issue 8 non-wb ops back-to-back with `oup_qready_i = 1` → 8 requests on consecutive cycles, first one cycle after acceptance, `qid`/payload matching, `busy_o = 0` throughout.
- **Hazard.** Issue `FLT_S` with rd = x5, then an op with wb and rd = x5 → second stalled (`core_ready_o = 0`) until the cycle after the `pid = 5` response; `busy_o[5]` pulses high in between.
- **Outstanding cap.** `MaxOutstanding = 4`; issue 5 wb ops to x1..x5 → fifth stalls; a response to x2 releases it the next cycle; `out_cnt` stays 4.
- **Backpressure.** Hold `oup_qready_i = 0` for 3 cycles with a request held → payload stable, `core_ready_o = 0`, no loss or duplication after release.
- **Simultaneous events / x0.**
  - Accept a wb op to x7 while a response for x3 handshakes → counter unchanged, `busy_o[7]` set, `busy_o[3]` cleared.
  - Issue a wb op to x0 → `busy_o[0]` stays 0 and its response decrements the count.
- **Errors / reset.**
  - A response with `pid = 9` while x9 is not busy → `unexpected_rsp_o` is set and sticky.
  - `perror` is forwarded on `wb_error_o`.
  - Asserting `rst_ni` low mid-stall → all outputs return to their reset values asynchronously.
